adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Triggered acquisition sequencer for the ADS412x sample stream, running on adc_clk after the
//  ADC config handshake. On arm it waits for a trigger (immediate, rising or falling level crossing),
//  stores capture_len decimated samples in an internal single-port RAM, then streams them out over
//  a valid/ready interface. Sits between the ADC driver's user_rd_data and the user readout logic.
// PARAMETERS
//  DW        12  sample width, two's-complement (bits)
//  AW        10  RAM address width; depth = 2**AW
//  DECIM_W    8  decimation ratio field width
// PORTS
//  adc_clk     in   1        clock; all logic on rising edge
//  rst_n       in   1        reset, synchronous, active-low
//  cfg_done    in   1        ADC configuration complete; low = controller held idle
//  sample_in   in   DW       ADC sample, one per adc_clk, signed
//  arm         in   1        start request, sampled only in IDLE
//  abort       in   1        cancel current operation
//  trig_mode   in   2        00 immediate, 01 rising, 10 falling, 11 = immediate
//  trig_level  in   DW       signed trigger threshold
//  capture_len in   AW+1     samples to store; 0 or >2**AW means 2**AW
//  decim       in   DECIM_W  keep 1 of every decim+1 samples
//  rd_data     out  DW       readout sample
//  rd_valid    out  1        rd_data valid
//  rd_last     out  1        final sample of capture, qualified by rd_valid
//  rd_ready    in   1        consumer accepts when rd_valid && rd_ready
//  busy        out  1        state != IDLE
//  done        out  1        one-cycle pulse after the last readout transfer
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, rd_valid/rd_last/busy/done = 0, rd_data = 0. RAM is not cleared.
//  - FSM: IDLE -> WAIT_TRIG -> CAPTURE -> READOUT -> IDLE.
//  - IDLE: if arm && cfg_done: latch trig_mode/trig_level/capture_len/decim, clear decim phase and
//    write address; next state CAPTURE (immediate) or WAIT_TRIG.
//  - Decimation: phase counter runs 0..decim_latched; sample is "taken" when phase == 0, so the
//    first taken sample is the one on the cycle after arm. decim = 0 takes every sample.
//  - WAIT_TRIG: on each taken sample compare with prev taken sample (signed).
//    Rising: prev < level && cur >= level. Falling: prev > level && cur <= level. The first taken
//    sample after arm only seeds prev and never triggers. The triggering sample is stored at addr 0
//    and the state becomes CAPTURE.
//  - CAPTURE: each taken sample is written at wr_addr and wr_addr increments. After the sample
//    with index len-1 is written, the state becomes READOUT.
//  - READOUT: RAM read latency is 1 cycle; a one-cycle prefetch precedes the first rd_valid.
//    Samples are output in write order, addr 0..len-1. While rd_valid && !rd_ready, rd_data,
//    rd_last and rd_valid are held stable. Back-to-back transfers sustain one per cycle.
//    rd_last = 1 only with addr len-1. On the transfer where rd_last is set: go to IDLE and
//    pulse done on the next cycle.
//  - Abort, or cfg_done low, in any non-IDLE state: IDLE on the next cycle. rd_valid drops,
//    no done pulse; a partial capture is discarded. Abort has priority over arm in the same cycle.
//  - arm outside IDLE is ignored; changes to config inputs outside IDLE have no effect.
//  - Samples arriving during READOUT are dropped. There is no overrun state.
//  - busy is registered and equals (state != IDLE).
// TESTING
//  1. Immediate, decim=0, len=4, ramp 0,1,2,..., arm at T -> reads 1,2,3,4; rd_last on 4;
//     done one cycle after the last transfer.
//  2. Rising, level=100, ramp from -50 step 10, len=2 -> reads 100,110.
//     Falling with the mirrored ramp -> reads -100,-110.
//  3. decim=2, immediate, len=3, ramp 0.. from the arm cycle -> reads 1,4,7.
//  4. rd_ready toggled 1-0-0-1 pseudo-randomly, len=8 -> data held stable while stalled,
//     all 8 values in order, exactly one rd_last.
//  5. Abort during CAPTURE after 2 samples, then a fresh arm with len=1 -> no done for the first
//     run; the second run returns 1 sample and pulses done.
//  6. Boundaries: len=0 -> 2**AW samples, last address wraps correctly. cfg_done=0 with arm ->
//     stays IDLE. rst_n low mid-READOUT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered, decimated sample capture into an internal RAM, then valid/ready readout
// Ports:
//   adc_clk, rst_n           clock and synchronous active-low reset
//   cfg_done                 ADC configured; low forces the controller to IDLE
//   sample_in                signed ADC sample, one per clock
//   arm, abort               start request (IDLE only) / cancel
//   trig_mode, trig_level    00/11 immediate, 01 rising, 10 falling; signed threshold
//   capture_len, decim       samples to store (0 or >2**AW = 2**AW); keep 1 of decim+1
//   rd_data, rd_valid,
//   rd_last, rd_ready        readout stream
//   busy, done               state != IDLE; one-cycle pulse after the final transfer
module adc_capture_ctrl #(
  parameter int DW = 12,
  parameter int AW = 10,
  parameter int DECIM_W = 8
) (
  input  logic               adc_clk,
  input  logic               rst_n,
  input  logic               cfg_done,
  input  logic [DW-1:0]      sample_in,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [DW-1:0]      trig_level,
  input  logic [AW:0]        capture_len,
  input  logic [DECIM_W-1:0] decim,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  input  logic               rd_ready,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READOUT} state_t;
  state_t state, state_nx;
  logic [1:0] mode;
  logic signed [DW-1:0] level, prev, cur;
  logic [AW-1:0] lm1, wr_addr, raddr, addr;
  logic [DECIM_W-1:0] dec, phase;
  logic seeded, start, kill, take, trig, wr_last, we, issue, fin;
  logic [DW-1:0] ram [2**AW];
  always_comb begin
    cur = sample_in;
    start = arm && cfg_done && !abort;
    kill = state != IDLE && (abort || !cfg_done);
    take = phase == '0;
    // the first taken sample after arm only seeds prev
    trig = seeded && (mode == 2'b01 ? prev < level && cur >= level : prev > level && cur <= level);
    wr_last = wr_addr == lm1;
    we = take && (state == CAPTURE || (state == WAIT_TRIG && trig));
    // one RAM read per cycle unless the presented word is stalled or is the last one
    issue = state == READOUT && (!rd_valid || (rd_ready && !rd_last));
    fin = rd_valid && rd_ready && rd_last;
    addr = state == READOUT ? raddr : wr_addr;
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = trig_mode[0] ^ trig_mode[1] ? WAIT_TRIG : CAPTURE;
      WAIT_TRIG: if (we) state_nx = wr_last ? READOUT : CAPTURE;
      CAPTURE:   if (we && wr_last) state_nx = READOUT;
      READOUT:   if (fin) state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end
  always_ff @(posedge adc_clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge adc_clk)
    if (we) ram[addr] <= sample_in;
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      {mode, level, prev, lm1, wr_addr, raddr, dec, phase, seeded} <= '0;
      {rd_data, rd_valid, rd_last, busy, done} <= '0;
    end else begin
      done <= fin && !kill;
      busy <= state_nx != IDLE;
      if (state == IDLE) begin
        if (start) begin
          mode <= trig_mode;
          level <= trig_level;
          lm1 <= capture_len[AW] ? '1 : AW'(capture_len[AW-1:0] - 1);
          dec <= decim;
        end
        phase <= '0;
        wr_addr <= '0;
        raddr <= '0;
        seeded <= 1'b0;
      end else begin
        phase <= phase == dec ? '0 : phase + 1;
        if (take && state == WAIT_TRIG) begin
          prev <= cur;
          seeded <= 1'b1;
        end
        if (we) wr_addr <= wr_addr + 1;
        if (issue) raddr <= raddr + 1;
      end
      if (issue) rd_data <= ram[addr];
      if (kill) begin
        rd_valid <= 1'b0;
        rd_last <= 1'b0;
      end else if (issue) begin
        rd_valid <= 1'b1;
        rd_last <= raddr == lm1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;
  logic adc_clk = 0, rst_n = 0, cfg_done = 1, arm = 0, abort = 0, rd_ready = 1;
  logic [11:0] sample_in = 0, trig_level = 0, rd_data;
  logic [1:0] trig_mode = 0;
  logic [10:0] capture_len = 0;
  logic [7:0] decim = 0;
  logic rd_valid, rd_last, busy, done;
  int checks = 0, errors = 0, step = 0;
  logic [11:0] cap [1024];
  int cap_n, n_last, last_idx, last_cyc, done_cyc, done_cnt, stall_err;

  adc_capture_ctrl dut (.adc_clk(adc_clk), .rst_n(rst_n), .cfg_done(cfg_done), .sample_in(sample_in),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_level(trig_level), .capture_len(capture_len),
    .decim(decim), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .done(done));

  always #5 adc_clk = ~adc_clk;

  task automatic tick();
    @(posedge adc_clk);
    #1;
    sample_in = sample_in + 12'(step);
  endtask

  task automatic start(input logic [1:0] m, input int lvl, input int len, input int d, input int s0, input int st);
    trig_mode = m; trig_level = 12'(lvl); capture_len = 11'(len); decim = 8'(d);
    sample_in = 12'(s0); step = st; arm = 1;
    tick();
    arm = 0;
  endtask

  // records every transfer; stall=1 drives rd_ready with the repeating pattern 1,0,0,1
  task automatic collect(input int budget, input bit stall);
    logic [3:0] pat = 4'b1001;
    logic [11:0] hd = 0;
    logic hl = 0;
    bit held = 0;
    cap_n = 0; n_last = 0; last_idx = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; stall_err = 0;
    for (int c = 0; c < budget; c++) begin
      rd_ready = stall ? pat[c % 4] : 1'b1;
      if (held && (rd_valid !== 1'b1 || rd_data !== hd || rd_last !== hl)) stall_err++;
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (rd_valid === 1'b1 && rd_ready) begin
        if (rd_last === 1'b1) begin n_last++; last_idx = cap_n; last_cyc = c; end
        cap[cap_n % 1024] = rd_data;
        cap_n++;
      end
      held = rd_valid === 1'b1 && !rd_ready; hd = rd_data; hl = rd_last;
      tick();
      if (done_cyc >= 0 && c > done_cyc + 1) break;
    end
    rd_ready = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b exp 0", rd_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rd_data !== 12'd0) begin errors++; $display("FAIL reset_rd_data got %0d exp 0", rd_data); end
    rst_n = 1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_immediate();
    start(2'b00, 0, 4, 0, 0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL imm_busy got %b exp 1", busy); end
    collect(100, 0);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL imm_count got %0d exp 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap[i] !== 12'(i + 1)) begin errors++; $display("FAIL imm_data[%0d] got %0d exp %0d", i, cap[i], i + 1); end
    end
    checks++; if (n_last !== 1 || last_idx !== 3) begin errors++; $display("FAIL imm_last got n=%0d idx=%0d exp n=1 idx=3", n_last, last_idx); end
    checks++; if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin errors++; $display("FAIL imm_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cyc, last_cyc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_trigger();
    start(2'b01, 100, 2, 0, -50, 10);
    collect(200, 0);
    checks++; if (cap_n !== 2 || cap[0] !== 12'd100 || cap[1] !== 12'd110) begin errors++; $display("FAIL rise_data got n=%0d %0d,%0d exp 2 100,110", cap_n, $signed(cap[0]), $signed(cap[1])); end
    start(2'b10, -100, 2, 0, 50, -10);
    collect(200, 0);
    checks++; if (cap_n !== 2 || cap[0] !== 12'(-100) || cap[1] !== 12'(-110)) begin errors++; $display("FAIL fall_data got n=%0d %0d,%0d exp 2 -100,-110", cap_n, $signed(cap[0]), $signed(cap[1])); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL fall_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_decim();
    start(2'b00, 0, 3, 2, 0, 1);
    collect(100, 0);
    checks++; if (cap_n !== 3 || cap[0] !== 12'd1 || cap[1] !== 12'd4 || cap[2] !== 12'd7) begin errors++; $display("FAIL decim_data got n=%0d %0d,%0d,%0d exp 3 1,4,7", cap_n, cap[0], cap[1], cap[2]); end
  endtask

  task automatic test_stall();
    int bad = 0;
    start(2'b11, 0, 8, 0, 0, 1);
    collect(200, 1);
    for (int i = 0; i < 8; i++) if (cap[i] !== 12'(i + 1)) bad++;
    checks++; if (cap_n !== 8 || bad !== 0) begin errors++; $display("FAIL stall_data got n=%0d bad=%0d exp n=8 bad=0", cap_n, bad); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", stall_err); end
    checks++; if (n_last !== 1 || last_idx !== 7) begin errors++; $display("FAIL stall_last got n=%0d idx=%0d exp n=1 idx=7", n_last, last_idx); end
    checks++; if (done_cyc !== last_cyc + 1) begin errors++; $display("FAIL stall_done got cyc=%0d exp %0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_abort();
    int seen = 0;
    start(2'b00, 0, 8, 0, 0, 1);
    repeat (2) tick();
    abort = 1;
    tick();
    abort = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    repeat (12) begin if (done === 1'b1 || rd_valid === 1'b1) seen++; tick(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", seen); end
    abort = 1;
    start(2'b00, 0, 4, 0, 0, 1);
    abort = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_arm got busy %b exp 0", busy); end
    start(2'b00, 0, 1, 0, 10, 1);
    collect(50, 0);
    checks++; if (cap_n !== 1 || cap[0] !== 12'd11) begin errors++; $display("FAIL rearm_data got n=%0d %0d exp 1 11", cap_n, cap[0]); end
    checks++; if (done_cnt !== 1 || n_last !== 1) begin errors++; $display("FAIL rearm_done got done=%0d last=%0d exp 1 1", done_cnt, n_last); end
  endtask

  task automatic test_boundaries();
    int bad = 0, w = 0;
    start(2'b00, 0, 0, 0, 0, 1);
    collect(2500, 0);
    for (int i = 0; i < 1024; i++) if (cap[i] !== 12'(i + 1)) bad++;
    checks++; if (cap_n !== 1024 || bad !== 0) begin errors++; $display("FAIL len0_data got n=%0d bad=%0d exp n=1024 bad=0", cap_n, bad); end
    checks++; if (n_last !== 1 || last_idx !== 1023 || cap[1023] !== 12'd1024) begin errors++; $display("FAIL len0_last got n=%0d idx=%0d val=%0d exp 1 1023 1024", n_last, last_idx, cap[1023]); end
    cfg_done = 0;
    start(2'b00, 0, 4, 0, 0, 1);
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nocfg_busy got %b exp 0", busy); end
    cfg_done = 1;
    rd_ready = 0;
    start(2'b00, 0, 8, 0, 0, 1);
    while (rd_valid !== 1'b1 && w < 40) begin tick(); w++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 12'd1) begin errors++; $display("FAIL rst_pre_valid got v=%b d=%0d exp v=1 d=1", rd_valid, rd_data); end
    rst_n = 0;
    tick();
    checks++; if ({rd_valid, rd_last, busy, done} !== 4'b0 || rd_data !== 12'd0) begin errors++; $display("FAIL rst_mid got v=%b l=%b b=%b d=%b data=%0d exp all 0", rd_valid, rd_last, busy, done, rd_data); end
    rst_n = 1;
    rd_ready = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_trigger();
    test_decim();
    test_stall();
    test_abort();
    test_boundaries();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
